// File: rtl/counter_pkg.sv
// ---------------------------------------------------------------------------
// counter_pkg : shared encodings and default widths for the counter family
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package counter_pkg;

  localparam int COUNTER_WIDTH = 8;
  localparam int STAT_WIDTH    = 16;

  typedef enum logic [1:0] {
    MON_UNLOCKED = 2'd0,
    MON_LOCKED   = 2'd1,
    MON_HOLD     = 2'd2
  } mon_state_e;

endpackage

`default_nettype wire

// File: rtl/counter_monitor_sat_counter.sv
// ---------------------------------------------------------------------------
// sat_counter : saturating up-counter with synchronous clear (clear then inc)
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;

  // A clear in the same cycle as an increment leaves the count at one.
  always_ff @(posedge clk) begin
    if (!reset) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= inc ? W'(1) : '0;
    end else if (inc && (count_q != '1)) begin
      count_q <= count_q + W'(1);
    end
  end

  assign count = count_q;

endmodule

`default_nettype wire

// File: rtl/counter_monitor.sv
// ---------------------------------------------------------------------------
// counter_monitor : locks onto a free-running counter and flags bad steps
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module counter_monitor
  import counter_pkg::*;
#(
  parameter int WIDTH = COUNTER_WIDTH,
  parameter int CNT_W = STAT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] value,
  input  logic             sample,
  input  logic             dut_reset,
  input  logic             clear,
  output logic             locked,
  output logic             mismatch,
  output logic             sticky_err,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] wrap_count,
  output logic [WIDTH-1:0] first_exp,
  output logic [WIDTH-1:0] first_got
);

  mon_state_e       state_q, state_d;
  logic [WIDTH-1:0] exp_q, exp_d;
  logic             locked_q, locked_d;
  logic             mismatch_q, mismatch_d;
  logic             sticky_q, sticky_d;
  logic [WIDTH-1:0] first_exp_q, first_exp_d;
  logic [WIDTH-1:0] first_got_q, first_got_d;
  logic             err_inc, wrap_inc, rep_hit;
  logic [WIDTH-1:0] rep_exp;

  always_comb begin
    state_d     = state_q;
    exp_d       = exp_q;
    sticky_d    = clear ? 1'b0 : sticky_q;
    first_exp_d = clear ? '0 : first_exp_q;
    first_got_d = clear ? '0 : first_got_q;
    wrap_inc    = 1'b0;
    rep_hit     = 1'b0;
    rep_exp     = '0;

    if (dut_reset) begin
      // The counter under reset must read zero; anything else is an error.
      state_d = MON_HOLD;
      if (sample && (value != '0)) begin
        rep_hit = 1'b1;
      end
    end else begin
      case (state_q)
        MON_LOCKED: begin
          if (sample) begin
            if (value == exp_q) begin
              exp_d    = exp_q + WIDTH'(1);
              wrap_inc = (value == '1);
            end else begin
              rep_hit = 1'b1;
              rep_exp = exp_q;
              exp_d   = value + WIDTH'(1);
            end
          end
        end
        default: begin
          state_d = sample ? MON_LOCKED : MON_UNLOCKED;
          if (sample) begin
            exp_d = value + WIDTH'(1);
          end
        end
      endcase
    end

    err_inc = rep_hit;
    if (rep_hit && !sticky_d) begin
      first_exp_d = rep_exp;
      first_got_d = value;
      sticky_d    = 1'b1;
    end

    locked_d   = (state_d == MON_LOCKED);
    mismatch_d = rep_hit;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= MON_UNLOCKED;
      exp_q       <= '0;
      locked_q    <= 1'b0;
      mismatch_q  <= 1'b0;
      sticky_q    <= 1'b0;
      first_exp_q <= '0;
      first_got_q <= '0;
    end else begin
      state_q     <= state_d;
      exp_q       <= exp_d;
      locked_q    <= locked_d;
      mismatch_q  <= mismatch_d;
      sticky_q    <= sticky_d;
      first_exp_q <= first_exp_d;
      first_got_q <= first_got_d;
    end
  end

  sat_counter #(.W(CNT_W)) u_err_cnt (
    .clk   (clk),
    .reset (reset),
    .clear (clear),
    .inc   (err_inc),
    .count (err_count)
  );

  sat_counter #(.W(CNT_W)) u_wrap_cnt (
    .clk   (clk),
    .reset (reset),
    .clear (clear),
    .inc   (wrap_inc),
    .count (wrap_count)
  );

  assign locked     = locked_q;
  assign mismatch   = mismatch_q;
  assign sticky_err = sticky_q;
  assign first_exp  = first_exp_q;
  assign first_got  = first_got_q;

endmodule

`default_nettype wire

// File: tb/tb_counter_monitor.sv
// ---------------------------------------------------------------------------
// tb_counter_monitor : directed vectors checked against a behavioural model
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_counter_monitor;

  localparam int WIDTH = 8;
  localparam int CNT_W = 4;
  localparam int VMAX  = (1 << WIDTH) - 1;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic [WIDTH-1:0] value = '0;
  logic             sample = 1'b0;
  logic             dut_reset = 1'b0;
  logic             clear = 1'b0;
  logic             locked, mismatch, sticky_err;
  logic [CNT_W-1:0] err_count, wrap_count;
  logic [WIDTH-1:0] first_exp, first_got;

  counter_monitor #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .value      (value),
    .sample     (sample),
    .dut_reset  (dut_reset),
    .clear      (clear),
    .locked     (locked),
    .mismatch   (mismatch),
    .sticky_err (sticky_err),
    .err_count  (err_count),
    .wrap_count (wrap_count),
    .first_exp  (first_exp),
    .first_got  (first_got)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;
  bit chk_en = 1'b0;

  // Behavioural model: "in sync" flag plus next expected value as plain ints.
  bit m_sync, m_mis, m_sticky;
  int m_exp, m_err, m_wrap, m_fe, m_fg;

  task automatic check(input string name, input int act, input int req);
    n_total++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
  endtask

  task automatic report(input int e, input int g);
    m_mis = 1'b1;
    if (m_err < CMAX) m_err++;
    if (!m_sticky) begin
      m_sticky = 1'b1;
      m_fe = e;
      m_fg = g;
    end
  endtask

  task automatic model_step(input bit r, input bit dr, input bit clr, input bit s, input int v);
    if (!r) begin
      m_sync = 0; m_mis = 0; m_sticky = 0;
      m_exp = 0; m_err = 0; m_wrap = 0; m_fe = 0; m_fg = 0;
      return;
    end
    if (clr) begin
      m_err = 0; m_wrap = 0; m_sticky = 0; m_fe = 0; m_fg = 0;
    end
    m_mis = 1'b0;
    if (dr) begin
      m_sync = 1'b0;
      if (s && v != 0) report(0, v);
    end else if (s) begin
      if (!m_sync) begin
        m_sync = 1'b1;
        m_exp = (v + 1) % (VMAX + 1);
      end else if (v == m_exp) begin
        m_exp = (m_exp + 1) % (VMAX + 1);
        if (v == VMAX && m_wrap < CMAX) m_wrap++;
      end else begin
        report(m_exp, v);
        m_exp = (v + 1) % (VMAX + 1);
      end
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("locked",     int'(locked),     int'(m_sync));
      check("mismatch",   int'(mismatch),   int'(m_mis));
      check("sticky_err", int'(sticky_err), int'(m_sticky));
      check("err_count",  int'(err_count),  m_err);
      check("wrap_count", int'(wrap_count), m_wrap);
      check("first_exp",  int'(first_exp),  m_fe);
      check("first_got",  int'(first_got),  m_fg);
    end
  end

  task automatic cyc(input bit r, input bit dr, input bit clr, input bit s, input int v);
    reset = r; dut_reset = dr; clear = clr; sample = s; value = WIDTH'(v);
    @(posedge clk);
    model_step(r, dr, clr, s, v);
    #1;
    reset = 1'b1; dut_reset = 1'b0; clear = 1'b0; sample = 1'b0;
  endtask

  task automatic do_reset();
    cyc(0, 0, 0, 1, 8'h33);
  endtask

  initial begin
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    chk_en = 1'b1;
    #4;
    check("rst_locked", int'(locked), 0);
    check("rst_err",    int'(err_count), 0);

    // Simple lock and in-order run.
    cyc(1, 0, 0, 1, 5);
    check("lock_after_first", int'(locked), 1);
    cyc(1, 0, 0, 1, 6);
    cyc(1, 0, 0, 1, 7);
    cyc(1, 0, 0, 0, 0);
    check("t1_err", int'(err_count), 0);

    // Wrap through all-ones.
    do_reset();
    cyc(1, 0, 0, 1, 8'hFD);
    cyc(1, 0, 0, 1, 8'hFE);
    cyc(1, 0, 0, 1, 8'hFF);
    cyc(1, 0, 0, 1, 8'h00);
    cyc(1, 0, 0, 1, 8'h01);
    check("t2_wrap", int'(wrap_count), 1);
    check("t2_err",  int'(err_count), 0);

    // Jump 0x10 -> 0x13, then 0x14 follows correctly.
    do_reset();
    cyc(1, 0, 0, 1, 8'h0F);
    cyc(1, 0, 0, 1, 8'h13);
    check("t3_pulse", int'(mismatch), 1);
    cyc(1, 0, 0, 1, 8'h14);
    check("t3_nopulse", int'(mismatch), 0);
    check("t3_err",  int'(err_count), 1);
    check("t3_fexp", int'(first_exp), 8'h10);
    check("t3_fgot", int'(first_got), 8'h13);

    // Counter held in reset, then released.
    do_reset();
    cyc(1, 0, 0, 1, 8'h20);
    cyc(1, 1, 0, 1, 0);
    check("t4_hold_unlocked", int'(locked), 0);
    cyc(1, 1, 0, 1, 0);
    cyc(1, 1, 0, 1, 3);
    cyc(1, 0, 0, 1, 0);
    check("t4_relock", int'(locked), 1);
    cyc(1, 0, 0, 1, 1);
    check("t4_err",  int'(err_count), 1);
    check("t4_fexp", int'(first_exp), 0);
    check("t4_fgot", int'(first_got), 3);

    // Clear coincident with a mismatch.
    do_reset();
    cyc(1, 0, 0, 1, 8'h00);
    for (int i = 0; i < 4; i++) cyc(1, 0, 0, 1, 8'h50);
    check("t5_err4", int'(err_count), 4);
    cyc(1, 0, 1, 1, 8'h77);
    check("t5_err",    int'(err_count), 1);
    check("t5_sticky", int'(sticky_err), 1);
    check("t5_fexp",   int'(first_exp), 8'h51);
    check("t5_fgot",   int'(first_got), 8'h77);

    // Saturation, then a mid-run reset.
    do_reset();
    cyc(1, 0, 0, 1, 8'h00);
    for (int i = 0; i < CMAX + 3; i++) cyc(1, 0, 0, 1, 8'h40);
    check("t6_sat", int'(err_count), CMAX);
    cyc(0, 0, 0, 1, 8'h41);
    check("t6_locked", int'(locked), 0);
    check("t6_err",    int'(err_count), 0);
    check("t6_sticky", int'(sticky_err), 0);
    check("t6_fexp",   int'(first_exp), 0);
    check("t6_fgot",   int'(first_got), 0);
    cyc(1, 0, 0, 0, 0);

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/counter_monitor.md
Name: counter_monitor

Overview:
- Consumer-side checker for the free-running `counter` block.
- Samples the counter's `value` bus and locks onto the sequence.
- Checks every sample against the expected increment, modulo 2^WIDTH.
- Reports mismatches, wrap-arounds and the first failing pair. Sits beside any counter instance in simulation or on-chip as a self-check.

Parameters:
- WIDTH, 8, width of the monitored counter value.
- CNT_W, 16, width of the err_count and wrap_count statistics counters.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-low; low on a clk edge resets the monitor.
- value  in  WIDTH  counter output being monitored.
- sample  in  1  value is valid for checking this cycle.
- dut_reset  in  1  the monitored counter's reset, active-high.
- clear  in  1  one-cycle pulse; clears statistics and the sticky state.
- locked  out  1  monitor is synchronised to the sequence.
- mismatch  out  1  one-cycle pulse per detected mismatch.
- sticky_err  out  1  set on the first mismatch; held until clear or reset.
- err_count  out  CNT_W  number of mismatches, saturating.
- wrap_count  out  CNT_W  number of checked all-ones→0 wraps, saturating.
- first_exp  out  WIDTH  expected value at the first mismatch.
- first_got  out  WIDTH  received value at the first mismatch.

Behaviour:
Reset and timing:
- Reset (reset=0 at a clk edge): state=UNLOCKED, exp=0. All outputs are 0: locked, mismatch, sticky_err, err_count, wrap_count, first_exp, first_got.
- All outputs are registered. An event sampled at edge N is visible after edge N; mismatch is high for exactly that one cycle.

States:
- UNLOCKED: no checking.
  - sample=1 → exp<=value+1 (mod 2^WIDTH), state→LOCKED.
  - locked=1 from the next cycle.
- LOCKED: on sample=1, compare value with exp.
  - Match: exp<=exp+1 mod 2^WIDTH. If value is all ones, wrap_count increments (saturating).
  - Mismatch: mismatch pulse; err_count increments (saturating at 2^CNT_W-1). If sticky_err was 0, capture first_exp=exp and first_got=value, then set sticky_err. Resynchronise with exp<=value+1 and stay LOCKED.
  - sample=0: no change.
- HOLD: entered from any state when dut_reset=1; locked=0.
  - Each sample with value≠0 is a mismatch against an expected value of 0 (same reporting as LOCKED).
  - Samples with value=0 are accepted silently.
  - When dut_reset=0: state→UNLOCKED, resync on the next sample.

Priorities and boundary cases:
- Priority: reset > dut_reset > sample. dut_reset=1 with sample=1 in the same cycle is evaluated as HOLD.
- clear coincident with a mismatch: clear is applied first, then the event. Result: err_count=1, sticky_err=1, first_* hold the new pair.
- clear coincident with a wrap: wrap_count=1.
- clear does not change state, exp or locked.
- Saturation: counters stop at all ones. No rollover; no flag.
- wrap_count counts only matched all-ones samples in LOCKED; resync jumps never count.
- Reset mid-operation discards all state, including sticky and first_* values.
- sample is ignored while reset=0.

Decomposition:
- Package counter_pkg holds:
  - state encoding: MON_UNLOCKED=2'd0, MON_LOCKED=2'd1, MON_HOLD=2'd2;
  - default constants COUNTER_WIDTH=8 and STAT_WIDTH=16.
- Sub-module sat_counter (params W; ports clk, reset, clear, inc, count) provides a saturating counter with synchronous clear. It is instantiated twice, for err_count and wrap_count.

Test Plan:
- Reset then sample value 5,6,7 on consecutive cycles → locked=1 after the first edge; mismatch never high; err_count=0.
- Lock at 8'hFD, feed FE,FF,00,01 → no mismatch; wrap_count=1.
- Locked with exp=8'h10, feed 8'h13 then 8'h14 → one mismatch pulse; err_count=1; sticky_err=1; first_exp=8'h10; first_got=8'h13; no second error.
- dut_reset=1 for 3 cycles with samples 0,0,3, then released and samples 0,1 → one mismatch (got 3, expected 0); locked=0 during HOLD; relock on the sample 0 after release; err_count=1.
- clear pulsed in the same cycle as a mismatch while err_count=4 → err_count=1; sticky_err=1; first_* hold the new pair.
- Force 2^CNT_W+2 mismatches (CNT_W=4 in the bench) → err_count holds at 4'hF. Then reset=0 for one edge → all outputs 0 and locked=0.
